prio_scan_encoder: RTL and testbench



---
 rtl/prio_scan_encoder.sv | 109 ++++++++++
 tb/tb_prio_scan_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prio_scan_encoder.sv
// Registered priority encoder with request buffering.
// Request pulses are merged into a pending vector, and one index at a time is
// offered on a valid/ready interface. The winner is either the highest pending
// index (RR=0) or the next pending index scanning downward from the round-robin
// pointer (RR=1).
module prio_scan_encoder #(
    parameter int N  = 8,
    parameter int RR = 0,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [N-1:0]  req_in,
    input  logic          ready_in,
    output logic          valid_out,
    output logic [IW-1:0] idx_out,
    output logic [N-1:0]  pending_out,
    output logic          overflow
);

    logic [N-1:0]  pending_reg;
    logic          valid_reg;
    logic [IW-1:0] idx_reg;
    logic          overflow_reg;
    logic [IW-1:0] ptr_reg;

    logic          acc;
    logic [N-1:0]  clr_mask;
    logic [N-1:0]  pending_next;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          overflow_hit;
    int            scan_j;

    assign acc = valid_reg & ready_in;

    // One-hot mask of the line being retired by this cycle's handshake.
    for (genvar gi = 0; gi < N; gi++) begin : g_clr_mask
        assign clr_mask[gi] = acc && (idx_reg == IW'(gi));
    end

    // A new request on the accepted line wins over the clear.
    assign pending_next = (pending_reg & ~clr_mask) | req_in;
    assign overflow_hit = |(req_in & pending_reg & ~clr_mask);
    assign ptr_next     = (acc && (RR != 0)) ? idx_reg : ptr_reg;

    // Choose the next winner from the post-update pending vector.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        scan_j     = 0;
        if (RR == 0) begin
            // Later (higher) indices overwrite earlier ones: highest wins.
            for (int i = 0; i < N; i++) begin
                if (pending_next[IW'(i)]) begin
                    pick_idx = IW'(i);
                end
            end
        end else begin
            // Scan ptr-1, ptr-2, ... wrapping through N-1 down to ptr itself.
            for (int k = 1; k <= N; k++) begin
                scan_j = int'(ptr_next) - k;
                if (scan_j < 0) begin
                    scan_j = scan_j + N;
                end
                if (!pick_found && pending_next[IW'(scan_j)]) begin
                    pick_found = 1'b1;
                    pick_idx   = IW'(scan_j);
                end
            end
        end
    end

    // State update: pending merge, pointer advance, offer reload or hold, sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg  <= '0;
            valid_reg    <= 1'b0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
            ptr_reg      <= '0;
        end else if (clr) begin
            pending_reg  <= '0;
            valid_reg    <= 1'b0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
            ptr_reg      <= '0;
        end else begin
            pending_reg <= pending_next;
            ptr_reg     <= ptr_next;
            if (overflow_hit) begin
                overflow_reg <= 1'b1;
            end
            // A stalled offer stays locked even if a better request arrives.
            if (!valid_reg || acc) begin
                valid_reg <= |pending_next;
                idx_reg   <= (|pending_next) ? pick_idx : '0;
            end
        end
    end

    assign valid_out   = valid_reg;
    assign idx_out     = idx_reg;
    assign pending_out = pending_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Self-checking bench for prio_scan_encoder: a fixed-priority and a
// round-robin instance share stimulus and are compared against a
// behavioural model of pending lines, offer and pointer.
module tb_prio_scan_encoder;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic [N-1:0]  req_in;
    logic          ready_in;

    logic          valid_out [2];
    logic [IW-1:0] idx_out [2];
    logic [N-1:0]  pending_out [2];
    logic          overflow [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance (0: fixed priority, 1: round-robin).
    bit        m_pend [2][N];
    bit        m_valid [2];
    int        m_idx [2];
    int        m_ptr [2];
    bit        m_ovf [2];

    always #5 clk = ~clk;

    prio_scan_encoder #(.N(N), .RR(0)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req_in(req_in), .ready_in(ready_in),
        .valid_out(valid_out[0]), .idx_out(idx_out[0]),
        .pending_out(pending_out[0]), .overflow(overflow[0])
    );

    prio_scan_encoder #(.N(N), .RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req_in(req_in), .ready_in(ready_in),
        .valid_out(valid_out[1]), .idx_out(idx_out[1]),
        .pending_out(pending_out[1]), .overflow(overflow[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pend_word(input int m);
        int w = 0;
        for (int i = 0; i < N; i++) if (m_pend[m][i]) w += (1 << i);
        return w;
    endfunction

    // Winner choice: highest index, or first pending when counting down from ptr-1 cyclically.
    function automatic int ref_pick(input int m);
        if (m == 0) begin
            for (int i = N - 1; i >= 0; i--) if (m_pend[m][i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int j = (m_ptr[m] - k + N) % N;
                if (m_pend[m][j]) return j;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) m_pend[m][i] = 0;
            m_valid[m] = 0; m_idx[m] = 0; m_ptr[m] = 0; m_ovf[m] = 0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input bit rd, input bit c);
        if (c) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            bit acc = m_valid[m] && rd;
            if (acc) m_pend[m][m_idx[m]] = 0;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if (m_pend[m][i]) m_ovf[m] = 1;
                    m_pend[m][i] = 1;
                end
            end
            if (acc && m == 1) m_ptr[m] = m_idx[m];
            if (!m_valid[m] || acc) begin
                m_valid[m] = (pend_word(m) != 0);
                m_idx[m]   = ref_pick(m);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_valid%0d", tag, m), 64'(valid_out[m]), 64'(m_valid[m]));
            check($sformatf("%s_idx%0d", tag, m), 64'(idx_out[m]), 64'(m_idx[m]));
            check($sformatf("%s_pend%0d", tag, m), 64'(pending_out[m]), 64'(pend_word(m)));
            check($sformatf("%s_ovf%0d", tag, m), 64'(overflow[m]), 64'(m_ovf[m]));
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, sample 1ns later.
    task automatic cycle(input logic [N-1:0] r, input bit rd, input bit c, input string tag);
        req_in = r; ready_in = rd; clr = c;
        @(posedge clk);
        model_edge(r, rd, c);
        #1;
        compare_all(tag);
        $display("cyc %s req=%02h rdy=%0b clr=%0b | fixed v=%0b i=%0d p=%02h o=%0b | rr v=%0b i=%0d p=%02h o=%0b",
                 tag, r, rd, c, valid_out[0], idx_out[0], pending_out[0], overflow[0],
                 valid_out[1], idx_out[1], pending_out[1], overflow[1]);
    endtask

    initial begin
        int exp3 [6] = '{5, 7, 3, 2, 1, 0};
        rst_n = 1'b0; clr = 1'b0; req_in = '0; ready_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_out[0]), 64'd0);
        check("rst_idx", 64'(idx_out[0]), 64'd0);
        check("rst_pend", 64'(pending_out[0]), 64'd0);
        check("rst_ovf", 64'(overflow[0]), 64'd0);
        rst_n = 1'b1;
        cycle(8'h00, 0, 0, "idle");

        // Burst drains highest first, one per cycle.
        cycle(8'h43, 1, 0, "t2a");
        check("t2_idx6", 64'(idx_out[0]), 64'd6);
        cycle(8'h00, 1, 0, "t2b");
        check("t2_idx1", 64'(idx_out[0]), 64'd1);
        cycle(8'h00, 1, 0, "t2c");
        check("t2_idx0", 64'(idx_out[0]), 64'd0);
        cycle(8'h00, 1, 0, "t2d");
        check("t2_empty", 64'({valid_out[0], pending_out[0]}), 64'd0);

        // Locked offer ignores a later higher-priority request.
        cycle(8'h2F, 0, 0, "t3a");
        check("t3_idx5", 64'(idx_out[0]), 64'd5);
        cycle(8'h00, 0, 0, "t3b");
        cycle(8'h80, 0, 0, "t3c");
        check("t3_locked", 64'(idx_out[0]), 64'd5);
        for (int k = 1; k < 6; k++) begin
            cycle(8'h00, 1, 0, "t3d");
            check($sformatf("t3_seq%0d", k), 64'(idx_out[0]), 64'(exp3[k]));
        end
        cycle(8'h00, 1, 0, "t3e");

        // Held requests: fixed starves line 3, round-robin alternates.
        cycle(8'h00, 0, 1, "t4clr");
        for (int k = 0; k < 4; k++) begin
            cycle(8'h18, 1, 0, "t4");
            check($sformatf("t4_fixed%0d", k), 64'(idx_out[0]), 64'd4);
            check($sformatf("t4_rr%0d", k), 64'(idx_out[1]), (k % 2 == 0) ? 64'd4 : 64'd3);
        end

        // Duplicate request sets sticky overflow; clr wipes everything.
        cycle(8'h00, 0, 1, "t5clr");
        cycle(8'h08, 0, 0, "t5a");
        cycle(8'h08, 0, 0, "t5b");
        check("t5_ovf", 64'(overflow[0]), 64'd1);
        check("t5_pend", 64'(pending_out[0]), 64'h08);
        cycle(8'h00, 0, 1, "t5c");
        check("t5_clr", 64'({overflow[0], valid_out[0], pending_out[0]}), 64'd0);

        // Steady single line, then asynchronous reset between edges.
        for (int k = 0; k < 3; k++) begin
            cycle(8'h01, 1, 0, "t6");
            check("t6_valid", 64'(valid_out[0]), 64'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_async", 64'({valid_out[0], idx_out[0], pending_out[0], overflow[0]}), 64'd0);
        compare_all("t6r");
        $display("async reset mid-cycle: v=%0b p=%02h", valid_out[0], pending_out[0]);
        #1 rst_n = 1'b1;
        cycle(8'h00, 0, 0, "t6idle");

        // Randomized traffic with occasional clear.
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            r = N'($urandom) & N'($urandom) & N'($urandom);
            cycle(r, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 63) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
